// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {IDLE, CONVERT} state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_if.sv
// Start/busy/done handshake and result bus between a requester and bin_to_bcd.
interface bin_to_bcd_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);
    assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter, one shift/adjust iteration per clock.
// Results are registered and held until the next conversion completes.
module bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input logic         clk,
    input logic         rst,
    bin_to_bcd_if.slave bus
);
    localparam int SW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH);
    localparam logic [63:0]   MAXV = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [SW-1:0] ALL9 = {DIGITS{4'h9}};

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [BIN_WIDTH-1:0]  sh, sh_nxt;
    logic [SW-1:0]         scr, scr_nxt, adj_f;
    logic [DIGITS-1:0][DIGIT_W-1:0] adj;
    logic                  ovf_r, ovf_out, done_r;
    logic [SW-1:0]         bcd_r;
    logic                  accept, last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_adjust u_adj (.d(scr[g*DIGIT_W +: DIGIT_W]), .q(adj[g]));
    end

    // Adjust then shift: binary MSB enters digit 0, top digit bit is dropped.
    assign adj_f   = adj;
    assign scr_nxt = {adj_f[SW-2:0], sh[BIN_WIDTH-1]};
    assign sh_nxt  = {sh[BIN_WIDTH-2:0], 1'b0};
    assign last    = (cnt == CW'(BIN_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept    = 1'b1;
                state_nxt = CONVERT;
            end
            CONVERT: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sh      <= '0;
            scr     <= '0;
            ovf_r   <= 1'b0;
            ovf_out <= 1'b0;
            bcd_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                sh    <= bus.bin;
                scr   <= '0;
                cnt   <= '0;
                ovf_r <= 64'(bus.bin) > MAXV;
            end else if (state == CONVERT) begin
                sh  <= sh_nxt;
                scr <= scr_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    bcd_r   <= ovf_r ? ALL9 : scr_nxt;
                    ovf_out <= ovf_r;
                    done_r  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (state == CONVERT);
    assign bus.done     = done_r;
    assign bus.bcd      = bcd_r;
    assign bus.overflow = ovf_out;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd with a queue scoreboard of expected results.
module tb_bin_to_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nerr = 0;
    int   nchk = 0;
    logic [15:0] q_bcd[$];
    logic        q_ovf[$];

    bin_to_bcd_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();
    bin_to_bcd #(.BIN_WIDTH(14), .DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int v, input bit push);
        bus.bin   = 14'(v);
        bus.start = 1'b1;
        if (push) begin
            q_bcd.push_back(model(v));
            q_ovf.push_back(v > 9999);
        end
    endtask

    // Called right after issue(); injects ignored starts at loop cycles ia/ib.
    task automatic await_done(input string tag, input int ia, input int ib);
        int k = 0;
        int busy_cnt = 0;
        bit seen = 0;
        bit both = 0;
        bit moved = 0;
        logic [15:0] held;
        logic [15:0] eb;
        logic        eo;
        held = bus.bcd;
        tick();
        bus.start = 1'b0;
        while (!seen && k < 40) begin
            if (bus.busy) busy_cnt++;
            if (k == ia || k == ib) begin
                bus.bin   = 14'd42;
                bus.start = 1'b1;
            end
            tick();
            k++;
            bus.start = 1'b0;
            if (bus.busy && bus.done) both = 1;
            seen = bus.done;
            if (!seen && bus.bcd !== held) moved = 1;
        end
        check({tag, " latency"}, 32'(k), 32'd14);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd14);
        check({tag, " busy_and_done"}, 32'(both), 32'd0);
        check({tag, " bcd_held_during"}, 32'(moved), 32'd0);
        if (q_bcd.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            eb = q_bcd.pop_front();
            eo = q_ovf.pop_front();
            check({tag, " bcd"}, 32'(bus.bcd), 32'(eb));
            check({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
        end
    endtask

    initial begin
        bit pulsed;
        logic [15:0] keep;
        bus.start = 1'b0;
        bus.bin   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset bcd", 32'(bus.bcd), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset overflow", 32'(bus.overflow), 32'h0);
        pulsed = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) pulsed = 1;
        end
        check("idle no_done", 32'(pulsed), 32'h0);
        check("idle bcd", 32'(bus.bcd), 32'h0);

        issue(1234, 1);
        await_done("c1234", -1, -1);
        keep = bus.bcd;
        tick();
        check("done one_cycle", 32'(bus.done), 32'h0);
        for (int i = 0; i < 50; i++) tick();
        check("hold 50", 32'(bus.bcd), 32'(keep));

        issue(0, 1);     await_done("c0", -1, -1);
        issue(9999, 1);  await_done("c9999", -1, -1);
        issue(10000, 1); await_done("c10000", -1, -1);
        issue(16383, 1); await_done("c16383", -1, -1);
        issue(7, 1);     await_done("c7", -1, -1);

        issue(5678, 1);  await_done("c5678", 3, 10);
        issue(42, 1);    await_done("c42_chain", -1, -1);

        tick();
        issue(4321, 0);
        tick();
        bus.start = 1'b0;
        pulsed = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) pulsed = 1;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort bcd", 32'(bus.bcd), 32'h0);
        check("abort busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) pulsed = 1;
        end
        check("abort no_done", 32'(pulsed), 32'h0);
        issue(4321, 1);  await_done("c4321", -1, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential double-dabble converter that turns an unsigned binary count into packed BCD digits for the 4-digit seven-segment display path. It sits directly upstream of the hex display driver: its `bcd` output connects unchanged to the driver's 16-bit `values` input, so counters and measurements display in decimal instead of hex. It performs one shift/adjust iteration per clock, uses a start/busy/done handshake, and holds the last result stable between conversions.

## Interface
Parameters:
- `BIN_WIDTH`, 14: width of the binary input. 14 bits covers 0..9999.
- `DIGITS`, 4: number of BCD output digits, 4 bits each.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a conversion. Sampled only in IDLE.
- `bin`, input, BIN_WIDTH: binary value. Captured on the accepting edge.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse; `bcd` and `overflow` were updated on the same edge.
- `bcd`, output, 4*DIGITS: packed BCD. Digit 0 (ones) is in [3:0]. Held between conversions.
- `overflow`, output, 1: last conversion input exceeded 10^DIGITS−1. Held with `bcd`.

## Operation
- States:
  - IDLE: waits for `start`.
  - CONVERT: runs one iteration per cycle.
- IDLE, `start`=1:
  - Capture `bin` into the shift register.
  - Clear the scratch BCD register and set iteration count to 0.
  - Register the overflow condition `bin > 10^DIGITS−1`.
  - Go to CONVERT.
- CONVERT, each cycle:
  - Add 3 to every scratch digit whose value is ≥5.
  - Shift {scratch, binary} left by 1; the binary MSB enters digit 0 LSB.
  - Increment the count.
- After the final iteration (count = BIN_WIDTH−1 at the edge):
  - Load `bcd` from scratch, or all-9s if overflow.
  - Load `overflow`, pulse `done`, return to IDLE.
- `start` in CONVERT is ignored. It is not queued.
- `start` in the cycle `done` is high is accepted, since the block is already in IDLE.
- `bcd`/`overflow` change only on the done edge. Downstream never sees intermediate values.
- Width rule: scratch register is 4*DIGITS bits. Any bits shifted out of the top digit are discarded; the overflow flag covers that case.
- Reset values:
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `bcd` = 0, `overflow` = 0
  - internal registers = 0
- Reset mid-conversion aborts the conversion: no `done` pulse, and `bcd` clears to 0.

## Timing
- Start accepted at edge E0. `busy` = 1 from after E0 through E14, i.e. exactly BIN_WIDTH cycles.
- Iterations occur on edges E1..E14.
- At E14: `bcd`/`overflow` are updated, `done` = 1 for one cycle, `busy` = 0.
- Latency from start edge to result: BIN_WIDTH cycles, the same for every input including overflow.
- Maximum throughput: one conversion per BIN_WIDTH cycles, by re-issuing `start` while `done` is high.
- `busy` and `done` are never high together.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `bcd_pkg`:
  - state enum {IDLE, CONVERT}
  - `DIGIT_W` = 4
  - constant `ADJ_THRESH` = 5
  - constant `ADJ_ADD` = 3
- Sub-module `bcd_digit_adjust`: combinational 4-bit add-3-if-≥5 cell. Instantiate DIGITS copies with a generate loop.
- Top-level `bin_to_bcd` holds the FSM, iteration counter (width clog2(BIN_WIDTH)), shift registers and output registers.

## Test plan
- Reset, then idle 20 cycles → `bcd` = 16'h0000, `busy` = 0, `done` never pulses, `overflow` = 0.
- `bin` = 1234, `start` pulse → `busy` high exactly 14 cycles; `done` one cycle at E14 with `bcd` = 16'h1234, `overflow` = 0; `bcd` unchanged 50 cycles later.
- `bin` = 0, then `bin` = 9999 → 16'h0000, then 16'h9999; `overflow` = 0 both times.
- `bin` = 10000, and `bin` = 16383 → `bcd` = 16'h9999, `overflow` = 1, latency still 14.
- Start 5678. Pulse `start` with `bin` = 42 at cycles 3 and 10. → Those starts are ignored and the result is 16'h5678. Then re-issue 42 during the `done` cycle → 16'h0042 exactly 14 cycles later.
- Start 4321, assert `rst` at cycle 7 → no `done`, `bcd` = 0, `busy` = 0. A new start of 4321 converts normally.
